// File: rtl/uart_pkg.sv
// Shared word format of the game-state UART link (selectors, MATCH_CTRL fields, byte order).
// Imported by both the transmit-side mux and the receive-side demux.
package uart_pkg;

  localparam logic [3:0] SEL_PL1_POSX   = 4'd1;
  localparam logic [3:0] SEL_PL1_POSY   = 4'd2;
  localparam logic [3:0] SEL_PL2_POSX   = 4'd3;
  localparam logic [3:0] SEL_PL2_POSY   = 4'd4;
  localparam logic [3:0] SEL_BALL_POSX  = 4'd5;
  localparam logic [3:0] SEL_BALL_POSY  = 4'd6;
  localparam logic [3:0] SEL_MATCH_CTRL = 4'd7;

  localparam int MC_RSVD_LSB   = 10;
  localparam int MC_END_GAME   = 9;
  localparam int MC_FLAG_POINT = 8;
  localparam int MC_P2_LSB     = 4;
  localparam int MC_P1_LSB     = 0;

  // Words travel as {sel, payload[11:8]} first, then payload[7:0].
  localparam bit HI_BYTE_FIRST = 1'b1;

  typedef enum logic {IDLE, WAIT_LO} asm_state_t;

  function automatic logic sel_valid(input logic [3:0] sel);
    return (sel >= SEL_PL1_POSX) && (sel <= SEL_MATCH_CTRL);
  endfunction

endpackage

// File: rtl/uart_word_asm.sv
// Pairs received bytes into 16-bit words, rejecting bad high bytes and stalled frames.
// Outputs are combinational on the low-byte/error cycle; no backpressure (rx strobes are never stalled).
module uart_word_asm
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [15:0] word,
  output logic        word_strobe,
  output logic        asm_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  asm_state_t      state;
  logic [7:0]      hi;
  logic [CW-1:0]   tcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_done && sel_valid(rx_data[7:4])) begin
            hi    <= rx_data;
            tcnt  <= '0;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte on the expiry cycle still completes the word.
          if (rx_done || tcnt == T_LAST) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    word        = HI_BYTE_FIRST ? {hi, rx_data} : {rx_data, hi};
    word_strobe = (state == WAIT_LO) && rx_done;
    asm_err     = ((state == IDLE) && rx_done && !sel_valid(rx_data[7:4])) ||
                  ((state == WAIT_LO) && !rx_done && (tcnt == T_LAST));
  end

endmodule

// File: rtl/uart_demux.sv
// Decodes reassembled UART words into the registered game-state bank and error counter.
// Latency: 1 cycle after the low byte's rx_done; no backpressure.
module uart_demux
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] pl2_posx,
  output logic [11:0] pl2_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        word_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  logic [15:0] word;
  logic        word_strobe;
  logic        asm_err;
  logic [3:0]  sel;
  logic [11:0] payload;
  logic        rsvd_bad;
  logic        err_now;

  uart_word_asm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .word        (word),
    .word_strobe (word_strobe),
    .asm_err     (asm_err)
  );

  always_comb begin
    sel      = word[15:12];
    payload  = word[11:0];
    rsvd_bad = (sel == SEL_MATCH_CTRL) && (payload[11:MC_RSVD_LSB] != 2'b00);
    err_now  = asm_err || (word_strobe && rsvd_bad);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pl1_posx   <= '0;
      pl1_posy   <= '0;
      pl2_posx   <= '0;
      pl2_posy   <= '0;
      ball_posx  <= '0;
      ball_posy  <= '0;
      pl1_score  <= '0;
      pl2_score  <= '0;
      flag_point <= 1'b0;
      end_game   <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      word_valid <= word_strobe && !rsvd_bad;
      frame_err  <= err_now;
      if (err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (word_strobe && !rsvd_bad) begin
        case (sel)
          SEL_PL1_POSX:  pl1_posx  <= payload;
          SEL_PL1_POSY:  pl1_posy  <= payload;
          SEL_PL2_POSX:  pl2_posx  <= payload;
          SEL_PL2_POSY:  pl2_posy  <= payload;
          SEL_BALL_POSX: ball_posx <= payload;
          SEL_BALL_POSY: ball_posy <= payload;
          SEL_MATCH_CTRL: begin
            end_game   <= payload[MC_END_GAME];
            flag_point <= payload[MC_FLAG_POINT];
            pl2_score  <= payload[MC_P2_LSB +: 4];
            pl1_score  <= payload[MC_P1_LSB +: 4];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_demux.md
# uart_demux

Receive-side counterpart of the game-state UART link. Takes the byte stream delivered by the UART receiver, reassembles 16-bit words `{sel[3:0], payload[11:0]}` sent high byte first, and validates the selector. Decodes each word into a bank of registered game-state outputs: player/ball positions, scores and match flags. Sits between the UART RX core and the game/draw logic on the slave board.

## Interface
- `TIMEOUT_CYCLES`, default 200000: maximum number of clocks allowed between the high byte and the low byte of one word.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_done` = 1.
- `rx_done`  in  1  one-cycle strobe from the UART RX core.
- `pl1_posx`, `pl1_posy`, `pl2_posx`, `pl2_posy`, `ball_posx`, `ball_posy`  out  12 each  decoded positions.
- `pl1_score`, `pl2_score`  out  4 each  decoded scores.
- `flag_point`  out  1  point-scored flag, level as last received.
- `end_game`  out  1  end-of-match flag, level as last received.
- `word_valid`  out  1  one-cycle strobe: a valid word was applied.
- `frame_err`  out  1  one-cycle strobe: a byte or word was rejected.
- `err_cnt`  out  8  saturating count of `frame_err` events.

## Operation
- **Selector codes:**
  - 1 = PL1_POSX
  - 2 = PL1_POSY
  - 3 = PL2_POSX
  - 4 = PL2_POSY
  - 5 = BALL_POSX
  - 6 = BALL_POSY
  - 7 = MATCH_CTRL
  - 0 and 8..15 are invalid.
- **MATCH_CTRL payload layout:**
  - [11:10] reserved, must be 0.
  - [9] `end_game`.
  - [8] `flag_point`.
  - [7:4] `pl2_score`.
  - [3:0] `pl1_score`.
- **FSM states:** IDLE, WAIT_LO.
- **IDLE, on `rx_done`:**
  - If `rx_data[7:4]` is in 1..7: latch the byte as the high byte, clear the timeout counter, go to WAIT_LO.
  - Otherwise: discard the byte, pulse `frame_err`, stay in IDLE. This is the resynchronisation mechanism.
- **WAIT_LO, on `rx_done`:**
  - Form word = {hi, `rx_data`} and return to IDLE.
  - Position selectors: write payload[11:0] to the matching register and pulse `word_valid`.
  - MATCH_CTRL with payload[11:10] = 0: update `end_game`, `flag_point` and both scores, and pulse `word_valid`.
  - MATCH_CTRL with payload[11:10] ≠ 0: no register update; pulse `frame_err`.
- **WAIT_LO, no `rx_done`:**
  - Increment the timeout counter.
  - When the counter reaches `TIMEOUT_CYCLES`−1: drop the high byte, pulse `frame_err`, go to IDLE.
- Only the register addressed by `sel` changes; all other outputs hold.
- `err_cnt` increments on every `frame_err` and saturates at 255.

## Timing
- **Reset:** while `rst_n` = 0 at a rising edge:
  - all outputs are set to 0, including positions, scores, flags, strobes and `err_cnt`;
  - the FSM goes to IDLE and the timeout counter is cleared.
- **Reset mid-frame:** a pending high byte is discarded without a `frame_err`.
- **Latency:** decoded registers and `word_valid` update on the clock edge that samples the low byte's `rx_done`. They are visible in the following cycle, i.e. one cycle after the `rx_done` cycle.
- **Error latency:** a rejected high byte produces `frame_err` with the same one-cycle latency.
- **Strobes:** `word_valid` and `frame_err` are never asserted in the same cycle and are high for exactly one cycle.
- **`rx_done` held high:** each high cycle counts as a new byte. The RX core guarantees single-cycle strobes; no handshake or back-pressure exists.
- **Timeout collision:** if `rx_done` arrives on the cycle the counter reaches `TIMEOUT_CYCLES`−1, `rx_done` wins. The byte completes the word and no timeout is flagged.
- **Timeout counter width:** `$clog2(TIMEOUT_CYCLES)`. The counter must not wrap; it is reset on every entry to WAIT_LO.

## Structure
- **Shared package `uart_pkg`:**
  - selector localparams (1..7);
  - MATCH_CTRL bit-field positions;
  - byte order convention (high byte first).
  - The transmit-side mux on the master board imports the same package.
- **Sub-module `uart_word_asm`:**
  - Contains the IDLE/WAIT_LO FSM, the high-byte latch and the timeout counter.
  - Outputs `word[15:0]`, `word_strobe` and `asm_err`.
- **Top-level `uart_demux`:**
  - Holds the selector decode, the output register bank and `err_cnt`.

## Test plan
- **Reset state:** bytes 0x1A, 0xBC → `pl1_posx` = 0xABC and one `word_valid`. Then drive `rst_n` = 0 for 1 cycle → all outputs 0.
- **MATCH_CTRL decode:** bytes 0x73, 0x5A → `end_game` = 1, `flag_point` = 1, `pl2_score` = 5, `pl1_score` = 0xA. All positions are unchanged.
- **Invalid high byte and resync:** bytes 0x0F, 0x95 → two `frame_err` pulses and `err_cnt` = 2. Then 0x61, 0x23 → `ball_posy` = 0x123 (resync).
- **Timeout:** byte 0x2F, then no byte for `TIMEOUT_CYCLES` → `frame_err` and back to IDLE. Next bytes 0x40, 0x07 → `pl2_posy` = 0x007.
- **Timeout collision:** low byte arrives exactly on the expiry cycle → word accepted and no `frame_err`.
- **Reserved bits and saturation:** bytes 0x74, 0x00 (reserved bits = 01) → `frame_err` and scores unchanged. Then 300 bad bytes → `err_cnt` = 255.
